usb_tx_encoder: RTL and testbench

// - Transmit-side line encoder for the full-speed USB link.
// - Serialises packet bytes LSB-first, inserts stuff bits, NRZI-encodes, then terminates with EOP.
// - Sits between the TX packet FSM (byte source) and the D+/D- pad drivers.
// - Output stream is decodable by the receive-path decoder and bit-unstuffer.

---
 rtl/usb_tx_encoder.sv | 180 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmit line encoder.
// Serialises packet bytes LSB-first, inserts a stuff 0 after STUFF_LEN
// consecutive transmitted 1s, NRZI-encodes onto D+/D- and closes with EOP.
// Build option: define USB_TX_SYNC_GEN_EN to generate the SYNC byte
// internally; otherwise the caller supplies 0x80 as the first byte.
// The line register is loaded on each bit strobe with the bit of the slot
// that is ending, so the line runs one bit period behind the state machine.
// This lets the one-cycle LOAD state overlap the final bit of the previous
// byte, and EOP_J spans two strobes so that J is visible for a full bit time
// before tx_done.
`timescale 1ns/1ps

module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [2:0] IDLE    = 3'd0;
`ifdef USB_TX_SYNC_GEN_EN
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [7:0] SYNC_PAT = 8'h80;
`endif
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] EOP_SE0 = 3'd4;
  localparam logic [2:0] EOP_J   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [OW-1:0] ones;
  logic [7:0]    shreg;
  logic          last_q;
  logic          line_j;
  logic          se0;
  logic          done_q;
  logic          err_q;
  logic          strobe;
  logic          stuff_now;

  assign strobe    = (state != IDLE) && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign stuff_now = (ones == OW'(STUFF_LEN));

  assign tx_ready = (state == LOAD);
  assign tx_busy  = (state != IDLE);
  assign tx_done  = done_q;
  assign tx_err   = err_q;
  assign d_plus   = ~se0 & line_j;
  assign d_minus  = ~se0 & ~line_j;

  // Bit timer: free-runs through each bit period while a packet is active
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      clk_cnt <= '0;
    else if (state == IDLE || strobe)
      clk_cnt <= '0;
    else
      clk_cnt <= clk_cnt + 1'b1;
  end

  // Packet sequencer, bit stuffer and NRZI line register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      ones    <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      line_j  <= 1'b1;
      se0     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
`ifdef USB_TX_SYNC_GEN_EN
            state <= SYNC;
`else
            state <= LOAD;
`endif
            bit_cnt <= '0;
            ones    <= '0;
            line_j  <= 1'b1;
            se0     <= 1'b0;
          end
        end
`ifdef USB_TX_SYNC_GEN_EN
        SYNC: begin
          if (strobe) begin
            if (!SYNC_PAT[bit_cnt[2:0]])
              line_j <= ~line_j;
            ones    <= SYNC_PAT[bit_cnt[2:0]] ? ones + 1'b1 : '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state   <= LOAD;
              bit_cnt <= '0;
            end
          end
        end
`endif
        LOAD: begin
          bit_cnt <= '0;
          if (tx_valid) begin
            shreg  <= tx_data;
            last_q <= tx_last;
            state  <= DATA;
          end else begin
            err_q <= 1'b1;
            state <= EOP_SE0;
          end
        end
        DATA: begin
          if (strobe) begin
            if (stuff_now) begin
              line_j <= ~line_j;
              ones   <= '0;
              if (bit_cnt == 4'd8) begin
                state   <= last_q ? EOP_SE0 : LOAD;
                bit_cnt <= '0;
              end
            end else begin
              if (!shreg[0])
                line_j <= ~line_j;
              ones    <= shreg[0] ? ones + 1'b1 : '0;
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && !(shreg[0] && ones == OW'(STUFF_LEN - 1))) begin
                state   <= last_q ? EOP_SE0 : LOAD;
                bit_cnt <= '0;
              end
            end
          end
        end
        EOP_SE0: begin
          if (strobe) begin
            se0     <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd1) begin
              state   <= EOP_J;
              bit_cnt <= '0;
            end
          end
        end
        EOP_J: begin
          if (strobe) begin
            se0     <= 1'b0;
            line_j  <= 1'b1;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd1) begin
              state   <= IDLE;
              bit_cnt <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed bench for usb_tx_encoder.
// Two encoders are instantiated (8 and 4 clocks per bit) sharing the byte
// interface; use4 selects which one is started and observed. The expected
// line is written per bit slot as J/K/0 (0 = SE0); slot s is visible from
// cycle (s+1)*n to (s+2)*n-1 after the start is taken.
// Works in both USB_TX_SYNC_GEN_EN builds: without it the bench feeds 0x80.
`timescale 1ns/1ps

module tb_usb_tx_encoder;

`ifdef USB_TX_SYNC_GEN_EN
  localparam int SYNC_EXTRA = 0;
`else
  localparam int SYNC_EXTRA = 1;
`endif

  localparam string T_2D   = "KJKJKJKKKJJJKKJK00J";
  localparam string T_FFFF = "KJKJKJKKKKKKKJJJJJJJKKKKKK00J";
  localparam string T_FC   = "KJKJKJKKJKKKKKKKJ00J";
  localparam string T_A5   = "KJKJKJKKKJJKJJKK00J";

  logic clk = 1'b0;
  logic n_rst;
  logic start8, start4, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic ready8, dp8, dm8, busy8, done8, err8;
  logic ready4, dp4, dm4, busy4, done4, err4;
  logic use4;
  logic obs_ready, obs_dp, obs_dm, obs_busy, obs_done, obs_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] pkt [$];
  bit pkt_last;
  int exp_readies;
  int err_at;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(8), .STUFF_LEN(6)) dut8 (
    .clk(clk), .n_rst(n_rst), .tx_start(start8), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(ready8),
    .d_plus(dp8), .d_minus(dm8), .tx_busy(busy8), .tx_done(done8), .tx_err(err8)
  );

  usb_tx_encoder #(.CLKS_PER_BIT(4), .STUFF_LEN(6)) dut4 (
    .clk(clk), .n_rst(n_rst), .tx_start(start4), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(ready4),
    .d_plus(dp4), .d_minus(dm4), .tx_busy(busy4), .tx_done(done4), .tx_err(err4)
  );

  assign obs_ready = use4 ? ready4 : ready8;
  assign obs_dp    = use4 ? dp4    : dp8;
  assign obs_dm    = use4 ? dm4    : dm8;
  assign obs_busy  = use4 ? busy4  : busy8;
  assign obs_done  = use4 ? done4  : done8;
  assign obs_err   = use4 ? err4   : err8;

  function automatic byte lineChar(input logic dp, input logic dm);
    if (dp === 1'b1 && dm === 1'b0) return "J";
    if (dp === 1'b0 && dm === 1'b1) return "K";
    if (dp === 1'b0 && dm === 1'b0) return "0";
    return "X";
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setPkt(input logic [7:0] b0, input logic [7:0] b1, input int nb, input bit last);
    pkt.delete();
`ifndef USB_TX_SYNC_GEN_EN
    pkt.push_back(8'h80);
`endif
    pkt.push_back(b0);
    if (nb > 1) pkt.push_back(b1);
    pkt_last = last;
  endtask

  task automatic driveByte(input int idx);
    if (idx < pkt.size()) begin
      tx_valid = 1'b1;
      tx_data  = pkt[idx];
      tx_last  = pkt_last && (idx == pkt.size() - 1);
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
    end
  endtask

  task automatic setStart(input logic v);
    if (use4) start4 = v;
    else      start8 = v;
  endtask

  task automatic applyStimulus(input string name, input string exp, input bit mid_start,
                               input bit restart, input int rst_at);
    int n, last_j, idx, readies, done_cnt;
    bit pending;
    byte want;
    n = use4 ? 4 : 8;
    last_j = (exp.len() + 1) * n;
    idx = 0;
    readies = 0;
    pending = 1'b0;
    @(negedge clk);
    setStart(1'b1);
    driveByte(0);
    @(negedge clk);
    setStart(1'b0);
    for (int j = 0; j <= last_j + 1; j++) begin
      if (j > 0) @(negedge clk);
      if (pending) begin
        idx++;
        driveByte(idx);
        pending = 1'b0;
      end
      setStart((mid_start && j == 5 * n) || (restart && j == last_j));
      if (obs_ready === 1'b1 && j < last_j) begin
        readies++;
        if (tx_valid) pending = 1'b1;
      end
      if (j < n || (j / n - 1) >= exp.len()) want = "J";
      else want = exp[j / n - 1];
      checkOutput($sformatf("%s line j=%0d", name, j), 32'(lineChar(obs_dp, obs_dm)), 32'(want));
      checkOutput($sformatf("%s busy j=%0d", name, j), 32'(obs_busy),
                  32'((j < last_j) || (restart && j == last_j + 1)));
      checkOutput($sformatf("%s done j=%0d", name, j), 32'(obs_done), 32'(j == last_j));
      checkOutput($sformatf("%s err j=%0d", name, j), 32'(obs_err), 32'(j == err_at));
      if (j == rst_at) break;
    end
    if (rst_at >= 0) begin
      tx_valid = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      checkOutput({name, " line at reset"}, 32'(lineChar(obs_dp, obs_dm)), 32'("J"));
      checkOutput({name, " busy at reset"}, 32'(obs_busy), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 20 * n; k++) begin
        @(negedge clk);
        if (obs_done !== 1'b0) done_cnt++;
      end
      checkOutput({name, " done pulses after reset"}, 32'(done_cnt), 32'd0);
      checkOutput({name, " line after reset"}, 32'(lineChar(obs_dp, obs_dm)), 32'("J"));
    end else begin
      checkOutput({name, " ready count"}, 32'(readies), 32'(exp_readies + SYNC_EXTRA));
    end
    setStart(1'b0);
  endtask

  task automatic waitIdle(input string name, input int bound);
    int k;
    for (k = 0; k < bound && obs_busy !== 1'b0; k++) @(negedge clk);
    checkOutput({name, " idle within bound"}, 32'(obs_busy), 32'd0);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  // Directed sequence: reset state, reset mid-DATA, packets, stuffing, underrun, restart, 4-clock bits
  initial begin
    n_rst = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    tx_valid = 1'b0;
    tx_last = 1'b0;
    tx_data = 8'h00;
    use4 = 1'b0;
    err_at = -1;
    exp_readies = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset line8", 32'(lineChar(dp8, dm8)), 32'("J"));
    checkOutput("reset line4", 32'(lineChar(dp4, dm4)), 32'("J"));
    checkOutput("reset ready", 32'(ready8), 32'd0);
    checkOutput("reset busy", 32'(busy8), 32'd0);
    checkOutput("reset done", 32'(done8), 32'd0);
    checkOutput("reset err", 32'(err8), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset during DATA");
    setPkt(8'h2D, 8'h00, 1, 1'b1);
    exp_readies = 1;
    applyStimulus("rst", T_2D, 1'b0, 1'b0, 13 * 8 + 3);

    $display("[TB] single byte 0x2D");
    applyStimulus("pid2d", T_2D, 1'b0, 1'b0, -1);

    $display("[TB] bytes 0xFF 0xFF with stuffing");
    setPkt(8'hFF, 8'hFF, 2, 1'b1);
    exp_readies = 2;
    applyStimulus("ffff", T_FFFF, 1'b0, 1'b0, -1);

    $display("[TB] byte 0xFC with stuff after last bit");
    setPkt(8'hFC, 8'h00, 1, 1'b1);
    exp_readies = 1;
    applyStimulus("fc", T_FC, 1'b0, 1'b0, -1);

    $display("[TB] underrun after 0xA5");
    setPkt(8'hA5, 8'h00, 1, 1'b0);
    exp_readies = 2;
    err_at = 16 * 8 + 1;
    applyStimulus("underrun", T_A5, 1'b0, 1'b0, -1);
    err_at = -1;

    $display("[TB] start while busy, then back-to-back start");
    setPkt(8'h2D, 8'h00, 1, 1'b1);
    exp_readies = 1;
    applyStimulus("busystart", T_2D, 1'b1, 1'b1, -1);
    tx_valid = 1'b1;
    tx_data  = 8'h80;
    tx_last  = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("restart line before first bit", 32'(lineChar(obs_dp, obs_dm)), 32'("J"));
    @(negedge clk);
    checkOutput("restart first bit K", 32'(lineChar(obs_dp, obs_dm)), 32'("K"));
    waitIdle("restart", 400);
    repeat (2) @(negedge clk);

    $display("[TB] 4 clocks per bit, byte 0x2D");
    use4 = 1'b1;
    setPkt(8'h2D, 8'h00, 1, 1'b1);
    exp_readies = 1;
    applyStimulus("bit4", T_2D, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
